// File: rtl/ifetch_pkg.sv
// Shared defaults for the instruction prefetch unit, plus the decode-side field positions.
// Width helpers keep counter and pointer sizing consistent between the unit and its FIFOs.
package ifetch_pkg;
  localparam int          XLEN_DEF     = 32;
  localparam int          DEPTH_DEF    = 4;
  localparam int          MAX_OUT_DEF  = 2;
  localparam int          OPC_W_DEF    = 4;
  localparam int          FUNCT_W_DEF  = 11;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          PC_STEP_DEF  = 4;
  // opcode is taken from the top of the word, funct from this bit upwards
  localparam int          FUNCT_LSB    = 0;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO with flush; a write becomes visible at the head the cycle after (no bypass).
// Flush wins over push/pop; a push into a full FIFO without a pop is dropped, so writers gate on count.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic                    valid,
  output logic [WIDTH-1:0]        head,
  output logic [cnt_w(DEPTH)-1:0] count
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // explicit wrap so non-power-of-two depths (e.g. a 3-deep tag queue) work
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign valid   = (count != '0);
  assign do_pop  = pop & valid;
  assign do_push = push & ((count != CW'(DEPTH)) | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= inc(wr_ptr);
      if (do_pop)  rd_ptr <= inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/ifetch_prefetch_unit.sv
// Sequential instruction prefetch: in-order fetches into a DEPTH-entry buffer, redirect flushes and drops stale data.
// Response reaches ins_valid one cycle after it returns; issue stalls so buffered + live requests never exceed DEPTH.
module ifetch_prefetch_unit
  import ifetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              DEPTH    = DEPTH_DEF,
  parameter int              MAX_OUT  = MAX_OUT_DEF,
  parameter int              OPC_W    = OPC_W_DEF,
  parameter int              FUNCT_W  = FUNCT_W_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int              PC_STEP  = PC_STEP_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      redirect_valid,
  input  logic [XLEN-1:0]           redirect_pc,
  output logic                      imem_req,
  output logic [XLEN-1:0]           imem_addr,
  input  logic                      imem_gnt,
  input  logic                      imem_rvalid,
  input  logic [XLEN-1:0]           imem_rdata,
  output logic                      ins_valid,
  input  logic                      ins_ready,
  output logic [XLEN-1:0]           ins,
  output logic [XLEN-1:0]           pc_new,
  output logic [OPC_W-1:0]          opcode,
  output logic [FUNCT_W-1:0]        funct,
  output logic [cnt_w(MAX_OUT)-1:0] outstanding
);
  localparam int OW = cnt_w(MAX_OUT);
  localparam int CW = cnt_w(DEPTH);

  logic [XLEN-1:0]   fetch_pc;
  logic [OW-1:0]     drop_cnt;
  logic [OW-1:0]     live_out;
  logic [OW-1:0]     out_nxt;
  logic [CW-1:0]     fifo_count;
  logic              accept;
  logic              resp;
  logic              drop;
  logic              keep;
  logic              tag_valid;
  logic [XLEN-1:0]   tag_pc;
  logic              fifo_valid;
  logic [2*XLEN-1:0] fifo_head;

  assign accept  = imem_req & imem_gnt;
  // a response with nothing in flight is a memory-side protocol error and is ignored
  assign resp    = imem_rvalid & (outstanding != '0);
  assign drop    = resp & (drop_cnt != '0);
  assign keep    = resp & ~drop & tag_valid;
  assign out_nxt = outstanding + OW'(accept) - OW'(resp);

  assign imem_req  = rst
                  && ((32'(fifo_count) + 32'(live_out)) < 32'(DEPTH))
                  && (32'(outstanding) < 32'(MAX_OUT));
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= out_nxt;
      if (redirect_valid) begin
        // everything still in flight after this edge, including a same-cycle accept, is stale
        fetch_pc <= redirect_pc;
        drop_cnt <= out_nxt;
      end else begin
        if (accept) fetch_pc <= fetch_pc + XLEN'(PC_STEP);
        if (drop)   drop_cnt <= drop_cnt - OW'(1);
      end
    end
  end

  // Address tags of live requests only; its occupancy is therefore outstanding - drop_cnt.
  ifetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUT)
  ) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (accept),
    .push_data (fetch_pc),
    .pop       (keep),
    .valid     (tag_valid),
    .head      (tag_pc),
    .count     (live_out)
  );

  ifetch_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_pf_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (keep),
    .push_data ({tag_pc, imem_rdata}),
    .pop       (ins_valid & ins_ready),
    .valid     (fifo_valid),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign ins_valid = fifo_valid;
  assign ins       = fifo_valid ? fifo_head[XLEN-1:0] : '0;
  assign pc_new    = fifo_valid ? fifo_head[2*XLEN-1:XLEN] : '0;
  assign opcode    = ins[XLEN-1 -: OPC_W];
  assign funct     = ins[FUNCT_LSB +: FUNCT_W];
endmodule

// File: tb/tb_ifetch_prefetch_unit.sv
// Bench for ifetch_prefetch_unit: directed scenarios plus random traffic against a request-level model
// (each in-flight fetch tracked as live or stale, delivered words kept as an address queue).
module tb_ifetch_prefetch_unit;
  localparam int          DEPTH   = 4;
  localparam int          MAX_OUT = 2;
  localparam logic [31:0] RST_PC  = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        ins_valid;
  logic        ins_ready = 1'b0;
  logic [31:0] ins;
  logic [31:0] pc_new;
  logic [3:0]  opcode;
  logic [10:0] funct;
  logic [1:0]  outstanding;

  ifetch_prefetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .ins_valid      (ins_valid),
    .ins_ready      (ins_ready),
    .ins            (ins),
    .pc_new         (pc_new),
    .opcode         (opcode),
    .funct          (funct),
    .outstanding    (outstanding)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        stale;
    logic [31:0] due;
  } req_t;

  req_t        pend[$];
  logic [31:0] buf_q[$];
  logic [31:0] exp_fetch;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          gnt_pct = 100, rdy_pct = 100, lat_lo = 0, lat_hi = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  function automatic int live_cnt();
    int n = 0;
    foreach (pend[i]) if (!pend[i].stale) n++;
    return n;
  endfunction

  function automatic logic exp_req_f();
    return rst && ((buf_q.size() + live_cnt()) < DEPTH) && (pend.size() < MAX_OUT);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    buf_q.delete();
    exp_fetch = RST_PC;
  endtask

  task automatic check_outputs(input string ph);
    logic [31:0] w;
    chk({ph, ".req"},  32'(imem_req), 32'(exp_req_f()));
    chk({ph, ".addr"}, imem_addr, exp_fetch);
    chk({ph, ".outs"}, 32'(outstanding), 32'(pend.size()));
    if (buf_q.size() > 0) begin
      w = mem_word(buf_q[0]);
      chk({ph, ".vld"},   32'(ins_valid), 32'd1);
      chk({ph, ".pc"},    pc_new, buf_q[0]);
      chk({ph, ".ins"},   ins, w);
      chk({ph, ".opc"},   32'(opcode), 32'(w[31:28]));
      chk({ph, ".funct"}, 32'(funct), 32'(w[10:0]));
    end else begin
      chk({ph, ".vld"},   32'(ins_valid), 32'd0);
      chk({ph, ".pc"},    pc_new, 32'd0);
      chk({ph, ".ins"},   ins, 32'd0);
      chk({ph, ".opc"},   32'(opcode), 32'd0);
      chk({ph, ".funct"}, 32'(funct), 32'd0);
    end
  endtask

  // One clock: drive inputs at edge+1, check at edge+3, advance the model on the edge.
  task automatic cycle(input logic rd, input logic [31:0] rpc);
    logic acc, pop, rv;
    req_t r;
    redirect_valid = rd;
    redirect_pc    = rpc;
    ins_ready      = ($urandom_range(99) < rdy_pct);
    imem_gnt       = ($urandom_range(99) < gnt_pct);
    rv             = (pend.size() > 0) && (pend[0].due <= 32'(cyc));
    imem_rvalid    = rv;
    imem_rdata     = rv ? mem_word(pend[0].addr) : $urandom();
    #2;
    check_outputs("cyc");
    assert (!(imem_rvalid && pend.size() == 0)) else begin
      fails++;
      $error("FAIL proto: rvalid with nothing in flight");
    end
    acc = exp_req_f() && imem_gnt;
    pop = (buf_q.size() > 0) && ins_ready;
    @(posedge clk);
    if (pop) void'(buf_q.pop_front());
    if (rv) begin
      r = pend.pop_front();
      if (!r.stale && !rd) buf_q.push_back(r.addr);
    end
    if (acc) begin
      r.addr  = exp_fetch;
      r.stale = rd;
      r.due   = 32'(cyc + 1 + int'($urandom_range(lat_hi, lat_lo)));
      pend.push_back(r);
      exp_fetch = exp_fetch + 32'd4;
    end
    if (rd) begin
      buf_q.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      exp_fetch = rpc;
    end
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0);
  endtask

  // Holds decode stalled until a word shows up, bounded.
  task automatic wait_head(input int limit);
    int k = 0;
    rdy_pct = 0;
    while (!ins_valid && k < limit) begin
      cycle(1'b0, 32'd0);
      k++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] wrap_seq [4];
    logic [31:0] t;
    int k;
    wrap_seq = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("rst");
    rst = 1'b1;

    // Zero-latency memory from a near-wrap reset PC
    gnt_pct = 100; rdy_pct = 100; lat_lo = 0; lat_hi = 0;
    run(2);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_seq", pc_new, wrap_seq[i]);
      cycle(1'b0, 32'd0);
    end
    run(6);

    // Decode stalled: buffer fills to DEPTH, then drains in order
    rdy_pct = 0;
    cycle(1'b1, 32'h0);
    run(12);
    chk("full.req", 32'(imem_req), 32'd0);
    chk("full.pc", pc_new, 32'h0);
    chk("full.vld", 32'(ins_valid), 32'd1);
    rdy_pct = 100;
    run(10);

    // Three-cycle memory latency
    lat_lo = 2; lat_hi = 2;
    run(30);

    // Redirect with two requests in flight
    k = 0;
    while (pend.size() != 2 && k < 50) begin
      cycle(1'b0, 32'd0);
      k++;
    end
    chk("wait_out2", 32'(outstanding), 32'd2);
    cycle(1'b1, 32'h100);
    wait_head(40);
    chk("redir.pc", pc_new, 32'h100);
    chk("redir.ins", ins, mem_word(32'h100));
    rdy_pct = 100;
    run(15);

    // Redirect on a cycle with pop and response, then a second redirect
    lat_lo = 0; lat_hi = 0;
    k = 0;
    while (!(buf_q.size() > 0 && pend.size() > 0 && pend[0].due <= 32'(cyc)) && k < 30) begin
      cycle(1'b0, 32'd0);
      k++;
    end
    chk("coinc.vld", 32'(ins_valid), 32'd1);
    cycle(1'b1, 32'h180);
    cycle(1'b1, 32'h200);
    wait_head(40);
    chk("redir2.pc", pc_new, 32'h200);
    rdy_pct = 100;
    run(15);

    // Random traffic with random redirects
    gnt_pct = 70; rdy_pct = 60; lat_lo = 0; lat_hi = 4;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99) < 3) begin
        t = $urandom();
        t[1:0] = 2'b00;
        if ($urandom_range(3) == 0) t = 32'hFFFF_FFF0 | (t & 32'h0000_000C);
        cycle(1'b1, t);
      end else begin
        cycle(1'b0, 32'd0);
      end
    end

    // Asynchronous reset mid-stream
    gnt_pct = 100; rdy_pct = 50; lat_lo = 0; lat_hi = 0;
    run(6);
    #2;
    rst = 1'b0;
    #1;
    chk("arst.req", 32'(imem_req), 32'd0);
    chk("arst.addr", imem_addr, RST_PC);
    chk("arst.outs", 32'(outstanding), 32'd0);
    chk("arst.vld", 32'(ins_valid), 32'd0);
    chk("arst.ins", ins, 32'd0);
    chk("arst.pc", pc_new, 32'd0);
    chk("arst.opc", 32'(opcode), 32'd0);
    chk("arst.funct", 32'(funct), 32'd0);
    imem_rvalid    = 1'b1;
    redirect_valid = 1'b0;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    chk("arst.rv_ign", 32'(ins_valid), 32'd0);
    chk("arst.outs2", 32'(outstanding), 32'd0);
    model_reset();
    rst = 1'b1;
    rdy_pct = 100;
    run(2);
    for (int i = 0; i < 4; i++) begin
      chk("restart_seq", pc_new, wrap_seq[i]);
      cycle(1'b0, 32'd0);
    end
    run(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
